// File: rtl/bit_mayor_if.sv
// Serial comparator bus: MSB-first operand bits in, registered decision out.
interface bit_mayor_if;
    logic bm_a;
    logic bm_b;
    logic bm_selector;
    logic bm_distintos;

    modport master (
        output bm_a,
        output bm_b,
        input  bm_selector,
        input  bm_distintos
    );

    modport slave (
        input  bm_a,
        input  bm_b,
        output bm_selector,
        output bm_distintos
    );
endinterface

// File: rtl/bit_mayor.sv
// Serial MSB-first magnitude comparator of two bit streams with registered decision outputs.
// Build option BIT_MAYOR_SERIAL_EN: word-framed sticky decision; otherwise a registered per-bit compare.
module bit_mayor #(
    parameter int unsigned WORD_LEN = 4
) (
    input logic        clk,
    input logic        reset,
    bit_mayor_if.slave bm
);

    if (WORD_LEN < 2 || WORD_LEN > 16) begin : g_word_len_check
        $error("bit_mayor: WORD_LEN must lie in 2..16");
    end

    logic sel_q;
    logic dist_q;
    logic sel_d;
    logic dist_d;
    logic bit_gt;
    logic bit_ne;

    // Single-bit verdict for the bit pair on the bus this cycle
    assign bit_gt = bm.bm_a & ~bm.bm_b;
    assign bit_ne = bm.bm_a ^ bm.bm_b;

`ifdef BIT_MAYOR_SERIAL_EN
    localparam int unsigned    CNT_W    = $clog2(WORD_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_LEN - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             word_start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    assign word_start = (cnt == '0);

    // First differing bit of a word wins; a new word always reloads
    always_comb begin
        sel_d  = sel_q;
        dist_d = dist_q;
        if (word_start || !dist_q) begin
            sel_d  = bit_gt;
            dist_d = bit_ne;
        end
    end
`else
    always_comb begin
        sel_d  = bit_gt;
        dist_d = bit_ne;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q  <= 1'b0;
            dist_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            dist_q <= dist_d;
        end
    end

    assign bm.bm_selector  = sel_q;
    assign bm.bm_distintos = dist_q;

endmodule

// File: tb/tb_bit_mayor.sv
// Self-checking bench for bit_mayor: prefix-compare model plus hand-computed word vectors.
module tb_bit_mayor;

    localparam int unsigned WL = 4;
`ifdef BIT_MAYOR_SERIAL_EN
    localparam int unsigned MODEL_WL = WL;
`else
    localparam int unsigned MODEL_WL = 1;
`endif

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    bit_mayor_if bm ();

    bit_mayor #(.WORD_LEN(WL)) dut (
        .clk   (clk),
        .reset (reset),
        .bm    (bm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the decision is the integer comparison of the bits seen so far in the current word
    int unsigned pos;
    int unsigned a_pre;
    int unsigned b_pre;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos   = 0;
            a_pre = 0;
            b_pre = 0;
        end else begin
            if (pos == 0) begin
                a_pre = 0;
                b_pre = 0;
            end
            a_pre = (a_pre << 1) | 32'(bm.bm_a);
            b_pre = (b_pre << 1) | 32'(bm.bm_b);
            pos   = (pos + 1) % MODEL_WL;
        end
    end

    task automatic check(input string name, input logic exp_sel, input logic exp_dist);
        vectors++;
        if (bm.bm_selector !== exp_sel || bm.bm_distintos !== exp_dist) begin
            miscompares++;
            $display("FAIL %s @%0t: got sel=%b dist=%b, want sel=%b dist=%b",
                     name, $time, bm.bm_selector, bm.bm_distintos, exp_sel, exp_dist);
        end
    endtask

    always @(negedge clk) begin
        check("model", a_pre > b_pre, a_pre != b_pre);
    end

    // Present one bit pair, let the next rising edge sample it, land 2ns after that edge
    task automatic apply(input logic a, input logic b);
        bm.bm_a = a;
        bm.bm_b = b;
        @(posedge clk);
        #2;
    endtask

    // exp_* bit 3 is the expectation after the first edge of the word, bit 0 after the last
    task automatic apply_word(input string name, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] exp_sel, input logic [3:0] exp_dist);
        for (int i = 3; i >= 0; i--) begin
            apply(a[i], b[i]);
`ifdef BIT_MAYOR_SERIAL_EN
            check($sformatf("%s_edge%0d", name, 4 - i), exp_sel[i], exp_dist[i]);
`endif
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        bm.bm_a     = 1'b0;
        bm.bm_b     = 1'b0;

        // Reset held low: clock and inputs toggle, outputs stay cleared
        @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'(i % 2));
            check("reset_hold", 1'b0, 1'b0);
        end
        reset = 1'b1;

        // Partial word, then asynchronous reset mid-cycle abandons it
        apply(1'b1, 1'b0);
        check("abort_first_bit", 1'b1, 1'b1);
        apply(1'b0, 1'b1);
        #1 reset = 1'b0;
        #1 check("async_clear", 1'b0, 1'b0);
        #2 reset = 1'b1;

        apply_word("eq_1011",   4'b1011, 4'b1011, 4'b0000, 4'b0000);
        apply_word("gt_1000",   4'b1000, 4'b0111, 4'b1111, 4'b1111);
        apply_word("lt_0010",   4'b0010, 4'b0011, 4'b0000, 4'b0001);
        apply_word("b2b_w1",    4'b1100, 4'b0100, 4'b1111, 4'b1111);
        apply_word("b2b_w2",    4'b0000, 4'b0100, 4'b0000, 4'b0111);

`ifndef BIT_MAYOR_SERIAL_EN
        apply(1'b0, 1'b0);
        check("sweep_00", 1'b0, 1'b0);
        apply(1'b0, 1'b1);
        check("sweep_01", 1'b0, 1'b1);
        apply(1'b1, 1'b0);
        check("sweep_10", 1'b1, 1'b1);
        apply(1'b1, 1'b1);
        check("sweep_11", 1'b0, 1'b0);
`endif

        // Pseudo-random bit streams, judged by the model on every falling edge
        for (int i = 0; i < 40; i++) begin
            apply(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bit_mayor.md
BIT_MAYOR -- requirements
Module: bit_mayor

Interface
REQ-001 The block SHALL have parameter WORD_LEN, default 4, giving the number of bits per serially compared word (range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port bm_a, input, 1 bit: current bit of operand A, MSB first.
REQ-005 The block SHALL have port bm_b, input, 1 bit: current bit of operand B, MSB first.
REQ-006 The block SHALL have port bm_selector, output, 1 bit: 1 = A is greater, 0 = B is greater or the operands are equal so far.
REQ-007 The block SHALL have port bm_distintos, output, 1 bit: 1 = a differing bit has been found (operands differ).

Function
REQ-008 The block SHALL drive both outputs directly from registers, with no combinational path from inputs to outputs.
REQ-009 The block SHALL sample bm_a/bm_b on every rising edge of clk while reset is high, and the result SHALL be visible one cycle after the sampling edge.
REQ-010 The block SHALL keep a bit counter cnt, 0..WORD_LEN-1, that increments on every clocked edge and wraps from WORD_LEN-1 to 0.
REQ-011 The block SHALL treat cnt==0 as the word start: it clears the prior decision, then loads bm_distintos=a^b and bm_selector=a&~b.
REQ-012 When cnt!=0 and bm_distintos==0, the block SHALL load bm_distintos=a^b and bm_selector=a&~b.
REQ-013 When cnt!=0 and bm_distintos==1, the block SHALL hold both outputs; later bits SHALL NOT change the decision (sticky MSB-first result).
REQ-014 The block SHALL guarantee bm_selector==1 implies bm_distintos==1, in every cycle.
REQ-015 At the end of a word (edge with cnt==WORD_LEN-1), the outputs SHALL show the full-word result: equal -> 0/0; A>B -> sel=1, dist=1; A<B -> sel=0, dist=1.
REQ-016 The word-start load (REQ-011) SHALL take priority over the hold rule, so back-to-back words need no idle cycle.

Reset
REQ-017 While reset is low, the block SHALL force bm_selector=0, bm_distintos=0 and cnt=0 immediately, independent of clk.
REQ-018 On reset deassertion, the first rising edge SHALL be treated as the word start (cnt==0).
REQ-019 If reset asserts mid-word, the block SHALL abandon the partial word, and the next word SHALL begin at the first edge after release.

Configuration
REQ-020 The block SHALL support macro BIT_MAYOR_SERIAL_EN as the only compile-time option.
REQ-021 With BIT_MAYOR_SERIAL_EN defined, the block SHALL implement REQ-010..REQ-016 (counter plus sticky decision).
REQ-022 Without BIT_MAYOR_SERIAL_EN, the block SHALL omit the counter and sticky logic, register bm_distintos=a^b and bm_selector=a&~b every cycle with one-cycle latency, and ignore WORD_LEN; reset behaviour is unchanged.

Verification (WORD_LEN=4, serial build unless noted)
REQ-023 Test: hold reset low, toggle clk and inputs -> outputs stay 0/0; assert reset asynchronously mid-cycle -> outputs clear before the next edge.
REQ-024 Test: A=1011, B=1011 -> after 4th edge sel=0, dist=0.
REQ-025 Test: A=1000, B=0111 -> after 1st edge sel=1, dist=1, held through the 4th edge despite later bits B>A.
REQ-026 Test: A=0010, B=0011 -> dist=0 for edges 1-3, then sel=0, dist=1 after the 4th edge.
REQ-027 Test: A=1100 then immediately A=0000, B=0100 both words -> word 1 gives sel=1, dist=1, then word 2's first edge reloads to 0/0 and its 2nd edge gives sel=0, dist=1.
REQ-028 Test (non-serial build): sweep (a,b)=00,01,10,11 one per cycle -> next cycle (sel,dist)=00,01,11,00.
